// File: rtl/cpu_pkg.sv
// Shared types for the writeback path: data width, register count, FIFO entry.
// No logic; constants and typedefs only.
// Imported by wb_fifo and writeback_arbiter.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RAW  = $clog2(NREG);

  typedef logic [RAW-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries buffering memory/muldiv results.
// Latency: a pushed entry is visible at head_o the cycle after the push edge.
// Backpressure: full_o is raised at DEPTH entries; the caller must not push when full.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    push_i,
  input  wb_entry_t               push_dat_i,
  input  logic                    pop_i,
  output wb_entry_t               head_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  wb_entry_t   mem_q [DEPTH];

  // Next-state pointer arithmetic; the low AW bits wrap modulo DEPTH.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i) wr_d = wr_q + 1'b1;
    if (pop_i)  rd_d = rd_q + 1'b1;
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign count_o = wr_q - rd_q;
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign empty_o = (wr_q == rd_q);

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU (priority) and buffered memory results onto the regfile write port; tracks busy regs.
// Latency: ALU result 1 cycle to wen/waddr/wdata; memory result at least 2 cycles.
// Backpressure: mem_ready = !full of the memory-result FIFO; the ALU path is always accepted.
module writeback_arbiter
  import cpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             issue_valid,
  input  logic [RAW-1:0]   issue_rd,
  input  logic             alu_valid,
  input  logic [RAW-1:0]   alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [RAW-1:0]   mem_rd,
  input  logic [XLEN-1:0]  mem_data,
  output logic             wen,
  output logic [RAW-1:0]   waddr,
  output logic [XLEN-1:0]  wdata,
  input  logic [RAW-1:0]   rs1,
  input  logic [RAW-1:0]   rs2,
  output logic             rs1_busy,
  output logic             rs2_busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wb_entry_t       head;
  logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CW-1:0]   fifo_cnt;

  logic            sel_vld;
  reg_addr_t       sel_rd;
  logic [XLEN-1:0] sel_data;

  logic            wen_q, wen_d;
  reg_addr_t       waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            rs1_busy_q, rs1_busy_d;
  logic            rs2_busy_q, rs2_busy_d;

  assign mem_ready = !fifo_full;
  assign fifo_push = mem_valid && mem_ready;
  // The FIFO head is consumed whenever the ALU leaves the write port free,
  // including when the head targets x0.
  assign fifo_pop  = !alu_valid && !fifo_empty;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push_i     (fifo_push),
    .push_dat_i ({mem_rd, mem_data}),
    .pop_i      (fifo_pop),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );

  // Commit mux, scoreboard update and hazard-flag next state.
  always_comb begin
    sel_vld  = alu_valid || !fifo_empty;
    sel_rd   = alu_valid ? alu_rd   : head.rd;
    sel_data = alu_valid ? alu_data : head.data;

    wen_d   = sel_vld && (sel_rd != '0);
    waddr_d = wen_d ? sel_rd   : waddr_q;
    wdata_d = wen_d ? sel_data : wdata_q;

    // Clear first so a same-edge issue to the same rd (the newer writer) wins.
    busy_d = busy_q;
    if (sel_vld) busy_d[sel_rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;

    // The in-flight write term covers the regfile's read-during-write old value.
    rs1_busy_d = (rs1 != '0) && (busy_q[rs1] || (wen_q && (waddr_q == rs1)));
    rs2_busy_d = (rs2 != '0) && (busy_q[rs2] || (wen_q && (waddr_q == rs2)));
  end

  // Write-port, scoreboard and hazard-flag registers; reset drops pending state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= '0;
      rs1_busy_q <= 1'b0;
      rs2_busy_q <= 1'b0;
    end else begin
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      rs1_busy_q <= rs1_busy_d;
      rs2_busy_q <= rs2_busy_d;
    end
  end

  // The occupancy can never exceed the buffer size while mem_ready gates pushes.
  always_ff @(posedge clk) begin
    if (resetn) assert (fifo_cnt <= CW'(FIFO_DEPTH));
  end

  assign wen      = wen_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign rs1_busy = rs1_busy_q;
  assign rs2_busy = rs2_busy_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             issue_valid = 1'b0;
  logic [RAW-1:0]   issue_rd = '0;
  logic             alu_valid = 1'b0;
  logic [RAW-1:0]   alu_rd = '0;
  logic [XLEN-1:0]  alu_data = '0;
  logic             mem_valid = 1'b0;
  logic             mem_ready;
  logic [RAW-1:0]   mem_rd = '0;
  logic [XLEN-1:0]  mem_data = '0;
  logic             wen;
  logic [RAW-1:0]   waddr;
  logic [XLEN-1:0]  wdata;
  logic [RAW-1:0]   rs1 = '0;
  logic [RAW-1:0]   rs2 = '0;
  logic             rs1_busy;
  logic             rs2_busy;

  writeback_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  // Expected observable state right after edge number cyc.
  typedef struct {
    int              cyc;
    logic            wen;
    logic [RAW-1:0]  addr;
    logic [XLEN-1:0] data;
    logic            b1;
    logic            b2;
  } exp_t;

  typedef struct {
    logic [RAW-1:0]  rd;
    logic [XLEN-1:0] data;
  } ent_t;

  exp_t exp_q[$];
  ent_t mq[$];                 // reference memory-result buffer
  bit   busy_m[NREG];          // reference scoreboard
  bit   last_wen = 0;
  logic [RAW-1:0] last_waddr = '0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare DUT outputs with the scoreboard away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check("wen", XLEN'(wen), XLEN'(e.wen));
        if (e.wen) begin
          check("waddr", XLEN'(waddr), XLEN'(e.addr));
          check("wdata", wdata, e.data);
        end
        check("rs1_busy", XLEN'(rs1_busy), XLEN'(e.b1));
        check("rs2_busy", XLEN'(rs2_busy), XLEN'(e.b2));
      end else if (resetn) begin
        check("unexpected_wen", XLEN'(wen), '0);
      end
    end
  end

  // Drive one cycle of inputs and record what the spec says must follow.
  task automatic step(input logic iv, input logic [RAW-1:0] ird,
                      input logic av, input logic [RAW-1:0] ard, input logic [XLEN-1:0] ad,
                      input logic mv, input logic [RAW-1:0] mrd, input logic [XLEN-1:0] md,
                      input logic [RAW-1:0] r1, input logic [RAW-1:0] r2);
    exp_t e;
    bit   ready_m, sel;
    logic [RAW-1:0]  srd;
    logic [XLEN-1:0] sd;
    ent_t h;
    @(posedge clk); #1;
    issue_valid = iv; issue_rd = ird;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    rs1 = r1; rs2 = r2;

    ready_m = (mq.size() < DEPTH);
    check("mem_ready", XLEN'(mem_ready), XLEN'(ready_m));

    e.cyc = cyc + 1;
    e.b1 = (r1 != 0) && (busy_m[r1] || (last_wen && last_waddr == r1));
    e.b2 = (r2 != 0) && (busy_m[r2] || (last_wen && last_waddr == r2));

    sel = 0; srd = '0; sd = '0;
    if (av) begin
      sel = 1; srd = ard; sd = ad;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      sel = 1; srd = h.rd; sd = h.data;
    end
    e.wen  = sel && (srd != 0);
    e.addr = srd;
    e.data = sd;

    if (sel) busy_m[srd] = 0;
    if (iv && ird != 0) busy_m[ird] = 1;

    if (mv && ready_m) begin
      h.rd = mrd; h.data = md;
      mq.push_back(h);
    end

    last_wen = e.wen;
    if (e.wen) last_waddr = srd;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [RAW-1:0] r1, input logic [RAW-1:0] r2);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, '0, 0, '0, '0, r1, r2);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    resetn = 1'b0;
    issue_valid = 0; alu_valid = 0; mem_valid = 0;
    #1;
    check("rst_wen", XLEN'(wen), '0);
    check("rst_waddr", XLEN'(waddr), '0);
    check("rst_wdata", wdata, '0);
    check("rst_rs1_busy", XLEN'(rs1_busy), '0);
    check("rst_rs2_busy", XLEN'(rs2_busy), '0);
    check("rst_mem_ready", XLEN'(mem_ready), 1);
    exp_q.delete();
    mq.delete();
    foreach (busy_m[i]) busy_m[i] = 0;
    last_wen = 0;
    last_waddr = '0;
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    idle(2, 5'd3, 5'd0);

    // Issue rd=5, ALU result next cycle, then watch the busy flag on rs1=5.
    step(1, 5'd5, 0, '0, '0, 0, '0, '0, 5'd0, 5'd0);
    step(0, '0, 1, 5'd5, 32'hDEADBEEF, 0, '0, '0, 5'd5, 5'd5);
    idle(3, 5'd5, 5'd0);

    // Read-during-write on rs1=7.
    step(1, 5'd7, 0, '0, '0, 0, '0, '0, 5'd0, 5'd0);
    step(0, '0, 1, 5'd7, 32'h0000_7777, 0, '0, '0, 5'd0, 5'd7);
    step(0, '0, 0, '0, '0, 0, '0, '0, 5'd7, 5'd0);
    idle(2, 5'd7, 5'd7);

    // ALU and memory every cycle: ALU wins, memory drains in order afterwards.
    for (int i = 0; i < 4; i++)
      step(0, '0, 1, RAW'(10 + i), 32'hA000_0000 + i, 1, RAW'(20 + i), 32'hB000_0000 + i, '0, '0);
    idle(6, '0, '0);

    // Fill the buffer while the ALU holds the port; fifth beat waits for a pop.
    for (int i = 0; i < 4; i++)
      step(0, '0, 1, 5'd1, 32'h1 + i, 1, RAW'(24 + i), 32'hC000_0000 + i, '0, '0);
    step(0, '0, 1, 5'd2, 32'h22, 1, 5'd28, 32'hC000_0004, '0, '0);
    step(0, '0, 0, '0, '0, 1, 5'd28, 32'hC000_0004, '0, '0);
    step(0, '0, 0, '0, '0, 1, 5'd28, 32'hC000_0004, '0, '0);
    idle(7, '0, '0);

    // x0 result is dropped; issue rd=9 on the edge rd=9 commits keeps it busy.
    step(0, '0, 1, 5'd0, 32'h1234, 0, '0, '0, '0, '0);
    step(1, 5'd9, 0, '0, '0, 0, '0, '0, '0, '0);
    step(1, 5'd9, 1, 5'd9, 32'h9999, 0, '0, '0, 5'd9, '0);
    idle(2, 5'd9, 5'd9);
    step(0, '0, 1, 5'd9, 32'h9A9A, 0, '0, '0, 5'd9, '0);
    idle(2, 5'd9, 5'd0);

    // Reset with three memory results pending: none may be written afterwards.
    for (int i = 0; i < 3; i++)
      step(0, '0, 1, 5'd4, 32'h40 + i, 1, RAW'(12 + i), 32'hE000_0000 + i, '0, '0);
    do_reset();
    idle(6, 5'd12, 5'd13);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 2) == 0, RAW'($urandom_range(0, NREG - 1)),
           $urandom_range(0, 1) == 1, RAW'($urandom_range(0, NREG - 1)), $urandom(),
           $urandom_range(0, 2) != 0, RAW'($urandom_range(0, NREG - 1)), $urandom(),
           RAW'($urandom_range(0, NREG - 1)), RAW'($urandom_range(0, NREG - 1)));
    end
    idle(8, '0, '0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", XLEN'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
